// File: rtl/mem_stage_lsu_if.sv
// Data-bus bundle between the memory-stage LSU and data memory / MMIO.
// Request fields are held from issue until ack or timeout abort.
interface mem_stage_lsu_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata, bus_err,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata, bus_err,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: bus handshake, stall, MEM/WB register.
// Define LSU_ALIGN_EXC_EN to trap misaligned half/word accesses.
module mem_stage_lsu #(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        int_clr,
  input  logic [31:0] IR_M_in,
  input  logic [31:0] PC8_M_in,
  input  logic [31:0] ALUOUT_M_in,
  input  logic [31:0] RT_M_in,
  output logic        stall,
  mem_stage_lsu_if.master bus,
  output logic [31:0] IR_W_out,
  output logic [31:0] PC8_W_out,
  output logic [31:0] ALUOUT_W_out,
  output logic [31:0] DR_W_out,
  output logic        adel_W_out,
  output logic        ades_W_out
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [7:0] TMAX = 8'(BUS_TIMEOUT - 1);

  state_t      state, state_n;
  logic [7:0]  timer, timer_n;
  logic        pend, pend_n;
  logic        issue;

  logic        is_ld, is_st, is_mem, sext, mis_exc;
  logic [1:0]  size, a;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;

  logic        we_q, ld_q, sext_q;
  logic [1:0]  size_q, a_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] ir_q, pc8_q, alu_q;

  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [31:0] ld_data;

  logic [31:0] ir_n, pc8_n, alu_n, dr_n;
  logic        adel_n, ades_n;

  // opcode decode, lane alignment, byte enables and store replication
  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    size  = SZ_W;
    sext  = 1'b0;
    unique case (1'b1)
      (IR_M_in[31:26] == 6'h20): begin is_ld = 1'b1; size = SZ_B; sext = 1'b1; end
      (IR_M_in[31:26] == 6'h21): begin is_ld = 1'b1; size = SZ_H; sext = 1'b1; end
      (IR_M_in[31:26] == 6'h23): begin is_ld = 1'b1; size = SZ_W; end
      (IR_M_in[31:26] == 6'h24): begin is_ld = 1'b1; size = SZ_B; end
      (IR_M_in[31:26] == 6'h25): begin is_ld = 1'b1; size = SZ_H; end
      (IR_M_in[31:26] == 6'h28): begin is_st = 1'b1; size = SZ_B; end
      (IR_M_in[31:26] == 6'h29): begin is_st = 1'b1; size = SZ_H; end
      (IR_M_in[31:26] == 6'h2B): begin is_st = 1'b1; size = SZ_W; end
      default: ;
    endcase
    is_mem = is_ld | is_st;
    a      = ALUOUT_M_in[1:0];
    if (size == SZ_H) a = {ALUOUT_M_in[1], 1'b0};
    if (size == SZ_W) a = 2'b00;
    be_in    = 4'b1111;
    wdata_in = RT_M_in;
    if (size == SZ_B) begin
      be_in    = 4'b0001 << a;
      wdata_in = {4{RT_M_in[7:0]}};
    end
    if (size == SZ_H) begin
      be_in    = a[1] ? 4'b1100 : 4'b0011;
      wdata_in = {2{RT_M_in[15:0]}};
    end
  end

`ifdef LSU_ALIGN_EXC_EN
  assign mis_exc = is_mem &
    (((size == SZ_H) & ALUOUT_M_in[0]) |
     ((size == SZ_W) & (|ALUOUT_M_in[1:0])));
`else
  assign mis_exc = 1'b0;
`endif

  // lane extraction and sign/zero extension of the returned word
  always_comb begin
    bsel = bus.bus_rdata[7:0];
    case (a_q)
      2'd1:    bsel = bus.bus_rdata[15:8];
      2'd2:    bsel = bus.bus_rdata[23:16];
      2'd3:    bsel = bus.bus_rdata[31:24];
      default: bsel = bus.bus_rdata[7:0];
    endcase
    hsel    = a_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    ld_data = bus.bus_rdata;
    if (size_q == SZ_B)
      ld_data = sext_q ? {{24{bsel[7]}}, bsel} : {24'b0, bsel};
    if (size_q == SZ_H)
      ld_data = sext_q ? {{16{hsel[15]}}, hsel} : {16'b0, hsel};
  end

  // next state, bus drive, stall and MEM/WB next values
  always_comb begin
    state_n       = state;
    timer_n       = timer;
    pend_n        = pend;
    issue         = 1'b0;
    stall         = 1'b0;
    bus.bus_req   = 1'b0;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = 32'b0;
    bus.bus_be    = 4'b0;
    bus.bus_wdata = 32'b0;
    bus.bus_err   = 1'b0;
    ir_n          = 32'b0;
    pc8_n         = PC8_W_out;
    alu_n         = 32'b0;
    dr_n          = 32'b0;
    adel_n        = 1'b0;
    ades_n        = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem && !mis_exc && !reset) begin
          issue         = 1'b1;
          stall         = 1'b1;
          bus.bus_req   = 1'b1;
          bus.bus_we    = is_st;
          bus.bus_addr  = {ALUOUT_M_in[31:2], 2'b00};
          bus.bus_be    = be_in;
          bus.bus_wdata = wdata_in;
          state_n       = WAIT;
          timer_n       = 8'd0;
          pend_n        = int_clr;
        end else if (!int_clr) begin
          pc8_n = PC8_M_in;
          alu_n = ALUOUT_M_in;
          if (mis_exc) begin
            adel_n = is_ld;
            ades_n = is_st;
          end else begin
            ir_n = IR_M_in;
          end
        end
      end
      WAIT: begin
        bus.bus_req   = 1'b1;
        bus.bus_we    = we_q;
        bus.bus_addr  = addr_q;
        bus.bus_be    = be_q;
        bus.bus_wdata = wdata_q;
        if (bus.bus_ack || timer == TMAX) begin
          bus.bus_err = !bus.bus_ack;
          state_n     = IDLE;
          pend_n      = 1'b0;
          if (!(int_clr || pend)) begin
            ir_n  = ir_q;
            pc8_n = pc8_q;
            alu_n = alu_q;
            if (bus.bus_ack && ld_q) dr_n = ld_data;
          end
        end else begin
          stall   = 1'b1;
          timer_n = timer + 8'd1;
          pend_n  = pend | int_clr;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state, timer, pending flush and MEM/WB register
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= 8'd0;
      pend         <= 1'b0;
      IR_W_out     <= 32'b0;
      PC8_W_out    <= 32'b0;
      ALUOUT_W_out <= 32'b0;
      DR_W_out     <= 32'b0;
      adel_W_out   <= 1'b0;
      ades_W_out   <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      pend         <= pend_n;
      IR_W_out     <= ir_n;
      PC8_W_out    <= pc8_n;
      ALUOUT_W_out <= alu_n;
      DR_W_out     <= dr_n;
      adel_W_out   <= adel_n;
      ades_W_out   <= ades_n;
    end
  end

  // capture the request at issue so the bus stays stable through WAIT
  always_ff @(posedge clk) begin
    if (issue) begin
      we_q    <= is_st;
      ld_q    <= is_ld;
      sext_q  <= sext;
      size_q  <= size;
      a_q     <= a;
      be_q    <= be_in;
      addr_q  <= {ALUOUT_M_in[31:2], 2'b00};
      wdata_q <= wdata_in;
      ir_q    <= IR_M_in;
      pc8_q   <= PC8_M_in;
      alu_q   <= ALUOUT_M_in;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: vector table plus scoreboard.
// Honours LSU_ALIGN_EXC_EN for the misaligned-access vectors.
module tb_mem_stage_lsu;

  typedef struct {
    logic [31:0] ir, pc8, alu, rt, rdata;
    int          ack_wait, clr_k;
    logic        req, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    int          nstall;
    logic        err;
    logic [31:0] ir_w, alu_w, dr_w;
    logic        adel, ades, hold;
  } vec_t;

  typedef struct {
    logic [31:0] ir, pc8, alu, dr;
    logic        adel, ades;
  } wexp_t;

  logic        clk = 1'b0;
  logic        reset, int_clr, stall;
  logic [31:0] IR_M_in, PC8_M_in, ALUOUT_M_in, RT_M_in;
  logic [31:0] IR_W_out, PC8_W_out, ALUOUT_W_out, DR_W_out;
  logic        adel_W_out, ades_W_out;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] prev_pc8 = 32'b0;
  wexp_t       sb_q[$];
  vec_t        tbl[$];

  mem_stage_lsu_if bus();

  mem_stage_lsu #(.BUS_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .int_clr(int_clr),
    .IR_M_in(IR_M_in), .PC8_M_in(PC8_M_in),
    .ALUOUT_M_in(ALUOUT_M_in), .RT_M_in(RT_M_in),
    .stall(stall), .bus(bus.master),
    .IR_W_out(IR_W_out), .PC8_W_out(PC8_W_out),
    .ALUOUT_W_out(ALUOUT_W_out), .DR_W_out(DR_W_out),
    .adel_W_out(adel_W_out), .ades_W_out(ades_W_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    wexp_t       e;
    logic [31:0] held;
    int          nst, nerr;
    logic        done, st;
    held   = prev_pc8;
    e.ir   = v.ir_w;
    e.pc8  = v.hold ? prev_pc8 : v.pc8;
    e.alu  = v.alu_w;
    e.dr   = v.dr_w;
    e.adel = v.adel;
    e.ades = v.ades;
    sb_q.push_back(e);
    prev_pc8      = e.pc8;
    IR_M_in       = v.ir;
    PC8_M_in      = v.pc8;
    ALUOUT_M_in   = v.alu;
    RT_M_in       = v.rt;
    bus.bus_rdata = v.rdata;
    nst  = 0;
    nerr = 0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      bus.bus_ack = (v.ack_wait >= 0) && (k == v.ack_wait + 1);
      int_clr     = (k == v.clr_k);
      #1;
      check("bus_req", bus.bus_req, v.req);
      if (v.req && bus.bus_req) begin
        check("bus_ctl", {bus.bus_we, bus.bus_be, bus.bus_addr},
              {v.we, v.be, v.addr});
        if (v.we) check("bus_wdata", bus.bus_wdata, v.wdata);
      end
      st = stall;
      if (st) nst++;
      if (bus.bus_err) nerr++;
      @(posedge clk);
      #1;
      if (st) begin
        check("bubble", {IR_W_out, ALUOUT_W_out}, 64'b0);
        check("bubble_pc8", PC8_W_out, held);
      end else begin
        done = 1'b1;
      end
      @(negedge clk);
    end
    bus.bus_ack = 1'b0;
    int_clr     = 1'b0;
    if (!done) begin
      n_cmp++;
      n_mis++;
      $display("FAIL completion: stall never released for ir %h", v.ir);
    end
    check("stall_cycles", nst, v.nstall);
    check("bus_err_pulses", nerr, v.err);
    e = sb_q.pop_front();
    check("ir_w", IR_W_out, e.ir);
    check("pc8_w", PC8_W_out, e.pc8);
    check("alu_w", ALUOUT_W_out, e.alu);
    check("dr_w", DR_W_out, e.dr);
    check("exc_w", {adel_W_out, ades_W_out}, {e.adel, e.ades});
  endtask

  initial begin
    reset         = 1'b1;
    int_clr       = 1'b0;
    IR_M_in       = 32'b0;
    PC8_M_in      = 32'b0;
    ALUOUT_M_in   = 32'b0;
    RT_M_in       = 32'b0;
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = 32'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ir_pc8", {IR_W_out, PC8_W_out}, 64'b0);
    check("rst_alu_dr", {ALUOUT_W_out, DR_W_out}, 64'b0);
    check("rst_ctl", {stall, bus.bus_req, bus.bus_err,
                      adel_W_out, ades_W_out}, 64'b0);
    reset = 1'b0;

    // ir pc8 alu rt rdata ackw clrk req we be addr wdata nst err irw aluw drw adel ades hold
    tbl.push_back('{32'h00851021, 32'h108, 32'h7, 32'h0, 32'h0, -1, -1,
      1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 0, 1'b0,
      32'h00851021, 32'h7, 32'h0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{32'hA0A20000, 32'h10C, 32'h13, 32'hAABBCCDD, 32'h0, 0, -1,
      1'b1, 1'b1, 4'b1000, 32'h10, 32'hDDDDDDDD, 1, 1'b0,
      32'hA0A20000, 32'h13, 32'h0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{32'h80A20000, 32'h110, 32'h2, 32'h0, 32'h00800000, 0, -1,
      1'b1, 1'b0, 4'b0100, 32'h0, 32'h0, 1, 1'b0,
      32'h80A20000, 32'h2, 32'hFFFFFF80, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{32'h90A20000, 32'h114, 32'h2, 32'h0, 32'h00800000, 0, -1,
      1'b1, 1'b0, 4'b0100, 32'h0, 32'h0, 1, 1'b0,
      32'h90A20000, 32'h2, 32'h00000080, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{32'h84A20000, 32'h118, 32'h6, 32'h0, 32'h80011234, 5, -1,
      1'b1, 1'b0, 4'b1100, 32'h4, 32'h0, 6, 1'b0,
      32'h84A20000, 32'h6, 32'hFFFF8001, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{32'h94A20000, 32'h11C, 32'h100, 32'h0, 32'h12348001, 0, -1,
      1'b1, 1'b0, 4'b0011, 32'h100, 32'h0, 1, 1'b0,
      32'h94A20000, 32'h100, 32'h00008001, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{32'h8CA20000, 32'h120, 32'h20, 32'h0, 32'hDEADBEEF, 2, -1,
      1'b1, 1'b0, 4'b1111, 32'h20, 32'h0, 3, 1'b0,
      32'h8CA20000, 32'h20, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{32'hA4A20000, 32'h124, 32'h22, 32'h1234ABCD, 32'h0, 1, -1,
      1'b1, 1'b1, 4'b1100, 32'h20, 32'hABCDABCD, 2, 1'b0,
      32'hA4A20000, 32'h22, 32'h0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{32'hACA20000, 32'h128, 32'h40, 32'hCAFEF00D, 32'h0, 0, -1,
      1'b1, 1'b1, 4'b1111, 32'h40, 32'hCAFEF00D, 1, 1'b0,
      32'hACA20000, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{32'h8CA20000, 32'h12C, 32'h80, 32'h0, 32'h55555555, -1, 5,
      1'b1, 1'b0, 4'b1111, 32'h80, 32'h0, 16, 1'b1,
      32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{32'h8CA20000, 32'h130, 32'h84, 32'h0, 32'h55555555, -1, -1,
      1'b1, 1'b0, 4'b1111, 32'h84, 32'h0, 16, 1'b1,
      32'h8CA20000, 32'h84, 32'h0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{32'h00851021, 32'h134, 32'h9, 32'h0, 32'h0, -1, 0,
      1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 0, 1'b0,
      32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{32'h80A20000, 32'h138, 32'h201, 32'h0, 32'h0000FF00, 0, -1,
      1'b1, 1'b0, 4'b0010, 32'h200, 32'h0, 1, 1'b0,
      32'h80A20000, 32'h201, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{32'h90A20000, 32'h13C, 32'h3, 32'h0, 32'hF1000000, 0, -1,
      1'b1, 1'b0, 4'b1000, 32'h0, 32'h0, 1, 1'b0,
      32'h90A20000, 32'h3, 32'h000000F1, 1'b0, 1'b0, 1'b0});
`ifdef LSU_ALIGN_EXC_EN
    tbl.push_back('{32'h8CA20000, 32'h140, 32'h5, 32'h0, 32'h11223344, 0, -1,
      1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 0, 1'b0,
      32'h0, 32'h5, 32'h0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{32'hA4A20000, 32'h144, 32'h23, 32'h0000BEEF, 32'h0, 0, -1,
      1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 0, 1'b0,
      32'h0, 32'h23, 32'h0, 1'b0, 1'b1, 1'b0});
`else
    tbl.push_back('{32'h8CA20000, 32'h140, 32'h5, 32'h0, 32'h11223344, 0, -1,
      1'b1, 1'b0, 4'b1111, 32'h4, 32'h0, 1, 1'b0,
      32'h8CA20000, 32'h5, 32'h11223344, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{32'hA4A20000, 32'h144, 32'h23, 32'h0000BEEF, 32'h0, 0, -1,
      1'b1, 1'b1, 4'b1100, 32'h20, 32'hBEEFBEEF, 1, 1'b0,
      32'hA4A20000, 32'h23, 32'h0, 1'b0, 1'b0, 1'b0});
`endif

    foreach (tbl[i]) apply(tbl[i]);

    // reset while a load waits on a silent bus
    IR_M_in     = 32'h8CA20000;
    PC8_M_in    = 32'h150;
    ALUOUT_M_in = 32'h30;
    repeat (3) @(negedge clk);
    #1;
    check("wait_req_before_reset", bus.bus_req, 1'b1);
    reset   = 1'b1;
    IR_M_in = 32'b0;
    @(negedge clk);
    #1;
    check("reset_mid_wait_ctl", {bus.bus_req, bus.bus_err, stall}, 64'b0);
    check("reset_mid_wait_w", {IR_W_out, PC8_W_out}, 64'b0);
    reset    = 1'b0;
    prev_pc8 = 32'b0;
    @(negedge clk);
    apply(tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
